// File: rtl/dma_axi_rd_master.sv
// Read-side AXI4 master for the DMA engine: one burst at a time (AR, then R beats),
// a 2-entry {data,last} output buffer and a sticky protocol-error record.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 512
`endif

package dma_axi_pkg;
    typedef enum logic [1:0] {
        DMA_NO_ERR   = 2'd0,
        DMA_RESP_ERR = 2'd1
    } e_dma_err_src_t;

    typedef struct packed {
        logic [31:0]                  addr;
        logic [7:0]                   alen;
        logic [2:0]                   size;
        logic [`DMA_DATA_WIDTH/8-1:0] strb;
        logic                         valid;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
        logic finish;
    } s_dma_axi_resp_t;

    typedef struct packed {
        logic           valid;
        e_dma_err_src_t src;
        logic [31:0]    addr;
    } s_dma_error_t;
endpackage

// state    | meaning
// ST_IDLE  | waiting for a request from the read streamer
// ST_AR    | address phase, arvalid held until arready
// ST_RDATA | collecting R beats into the output buffer
module dma_axi_rd_master
    import dma_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         DATA_W = `DMA_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  s_dma_axi_req_t    dma_axi_req_i,
    output s_dma_axi_resp_t   dma_axi_resp_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [31:0]       araddr_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic [3:0]        arid_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic [3:0]        rid_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    input  logic              rd_ready_i,
    output s_dma_error_t      rd_err_o,
    input  logic              err_clr_i
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_AR    = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    logic [1:0]        state;
    logic [31:0]       ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [7:0]        cnt;
    logic              ready_q;
    logic              finish_q;
    logic [DATA_W-1:0] buf_data [2];
    logic [1:0]        buf_last;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    s_dma_error_t      err_q;

    logic beat;
    logic at_len;
    logic last_beat;
    logic beat_err;
    logic pop;
    logic unused_strb;

    assign unused_strb = ^dma_axi_req_i.strb;

    assign at_len    = (cnt == ar_len);
    assign rready_o  = (state == ST_RDATA) && (count < 2'd2);
    assign beat      = rready_o && rvalid_i && (rid_i == AXI_ID);
    assign last_beat = rlast_i || at_len;
    // cnt never passes ar_len, so rlast disagreeing with at_len is exactly early-or-missing last
    assign beat_err  = (rresp_i != 2'b00) || (rlast_i != at_len);
    assign pop       = (count != 2'd0) && rd_ready_i;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            ar_addr     <= '0;
            ar_len      <= '0;
            ar_size     <= '0;
            cnt         <= '0;
            ready_q     <= 1'b0;
            finish_q    <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            err_q       <= '0;
        end else begin
            ready_q  <= 1'b0;
            finish_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dma_axi_req_i.valid) begin
                        ar_addr <= dma_axi_req_i.addr;
                        ar_len  <= dma_axi_req_i.alen;
                        ar_size <= dma_axi_req_i.size;
                        cnt     <= '0;
                        state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (arready_i) begin
                        state   <= ST_RDATA;
                        ready_q <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (beat) begin
                        cnt <= cnt + 8'd1;
                        if (last_beat) begin
                            state    <= ST_IDLE;
                            finish_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (beat) begin
                buf_data[wr_ptr] <= rdata_i;
                buf_last[wr_ptr] <= last_beat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (beat && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !beat) begin
                count <= count - 2'd1;
            end

            if (err_clr_i) begin
                err_q <= '0;
            end else if (beat && beat_err && !err_q.valid) begin
                err_q.valid <= 1'b1;
                err_q.src   <= DMA_RESP_ERR;
                err_q.addr  <= ar_addr;
            end
        end
    end

    assign dma_axi_resp_o.ready  = ready_q;
    assign dma_axi_resp_o.finish = finish_q;
    assign arvalid_o  = (state == ST_AR);
    assign araddr_o   = ar_addr;
    assign arlen_o    = ar_len;
    assign arsize_o   = ar_size;
    assign arburst_o  = 2'b01;
    assign arid_o     = AXI_ID;
    assign rd_data_o  = buf_data[rd_ptr];
    assign rd_last_o  = buf_last[rd_ptr];
    assign rd_valid_o = (count != 2'd0);
    assign rd_err_o   = err_q;
endmodule

// File: tb/tb_dma_axi_rd_master.sv
// Randomized bench for dma_axi_rd_master: a queue-based behavioural model is compared
// against the DUT every cycle, plus directed scenarios with hand-computed expectations.
module tb_dma_axi_rd_master;
    import dma_axi_pkg::*;

    localparam int         DW = 512;
    localparam logic [3:0] ID = 4'd3;

    logic            clk;
    logic            rstn;
    s_dma_axi_req_t  req;
    s_dma_axi_resp_t resp;
    logic            arvalid_o, arready_i;
    logic [31:0]     araddr_o;
    logic [7:0]      arlen_o;
    logic [2:0]      arsize_o;
    logic [1:0]      arburst_o;
    logic [3:0]      arid_o;
    logic            rvalid_i, rready_o, rlast_i;
    logic [DW-1:0]   rdata_i, rd_data_o;
    logic [1:0]      rresp_i;
    logic [3:0]      rid_i;
    logic            rd_valid_o, rd_last_o, rd_ready_i;
    s_dma_error_t    rd_err_o;
    logic            err_clr_i;

    dma_axi_rd_master #(.AXI_ID(ID), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn),
        .dma_axi_req_i(req), .dma_axi_resp_o(resp),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .rid_i(rid_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o),
        .rd_ready_i(rd_ready_i), .rd_err_o(rd_err_o), .err_clr_i(err_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    // model: phase 0 = no burst, 1 = address pending, 2 = collecting data
    beat_t       mq[$];
    beat_t       pops[$];
    int          m_phase = 0;
    logic [31:0] m_addr = '0;
    logic [7:0]  m_len = '0;
    logic [2:0]  m_size = '0;
    int          m_idx = 0;
    logic        m_ready = 1'b0, m_finish = 1'b0, m_err_v = 1'b0;
    logic [31:0] m_err_addr = '0;

    int checks = 0, errors = 0;
    int n_ready = 0, n_finish = 0;
    int bp_mode = 0;
    bit chk_en = 1'b0;
    logic [31:0] ar_addr_cap;
    logic [7:0]  ar_len_cap;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit rr, lst, e;
        if (!rstn) begin
            mq.delete();
            m_phase = 0; m_ready = 0; m_finish = 0;
            m_err_v = 0; m_err_addr = '0;
            m_addr = '0; m_len = '0; m_size = '0; m_idx = 0;
        end else begin
            rr = (m_phase == 2) && (mq.size() < 2);
            m_ready = 0; m_finish = 0; e = 0;
            if (mq.size() > 0 && rd_ready_i) void'(mq.pop_front());
            case (m_phase)
                0: if (req.valid) begin
                    m_addr = req.addr; m_len = req.alen; m_size = req.size;
                    m_idx = 0; m_phase = 1;
                end
                1: if (arready_i) begin
                    m_phase = 2; m_ready = 1;
                end
                default: if (rr && rvalid_i && rid_i == ID) begin
                    lst = rlast_i || (m_idx == int'(m_len));
                    e = (rresp_i != 2'b00) || (rlast_i && m_idx < int'(m_len))
                        || (m_idx == int'(m_len) && !rlast_i);
                    mq.push_back('{rdata_i, lst});
                    m_idx++;
                    if (lst) begin
                        m_phase = 0; m_finish = 1;
                    end
                end
            endcase
            if (err_clr_i) begin
                m_err_v = 0; m_err_addr = '0;
            end else if (e && !m_err_v) begin
                m_err_v = 1; m_err_addr = m_addr;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("arvalid", arvalid_o, m_phase == 1);
            if (m_phase == 1) begin
                chk("araddr", araddr_o, m_addr);
                chk("arlen", arlen_o, m_len);
                chk("arsize", arsize_o, m_size);
            end
            chk("arburst", arburst_o, 2'b01);
            chk("arid", arid_o, ID);
            chk("rready", rready_o, (m_phase == 2) && (mq.size() < 2));
            chk("rd_valid", rd_valid_o, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rd_data", rd_data_o, mq[0].data);
                chk("rd_last", rd_last_o, mq[0].last);
            end
            chk("resp_ready", resp.ready, m_ready);
            chk("resp_finish", resp.finish, m_finish);
            chk("err_valid", rd_err_o.valid, m_err_v);
            chk("err_src", rd_err_o.src, m_err_v ? DMA_RESP_ERR : DMA_NO_ERR);
            chk("err_addr", rd_err_o.addr, m_err_addr);
            if (resp.ready) n_ready++;
            if (resp.finish) n_finish++;
            if (rd_valid_o && rd_ready_i) pops.push_back('{rd_data_o, rd_last_o});
        end
        model_step();
    end

    initial begin
        rd_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0: rd_ready_i = 1'b1;
                1: rd_ready_i = ~rd_ready_i;
                2: rd_ready_i = 1'($urandom_range(0, 1));
                default: rd_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic send_beat(input logic [1:0] resp_v, input logic last_v);
        int t;
        bit acc;
        rvalid_i = 1'b1; rdata_i = rand_data(); rresp_i = resp_v;
        rlast_i = last_v; rid_i = ID;
        t = 0;
        do begin
            @(negedge clk); acc = rready_o;
            @(posedge clk); #1; t++;
        end while (!acc && t < 100);
        chk("beat_accept", acc, 1'b1);
        rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
    endtask

    task automatic start_req(input logic [31:0] addr, input logic [7:0] alen,
                             input logic [2:0] size, input int ar_stall);
        int t;
        @(posedge clk); #1;
        req.addr = addr; req.alen = alen; req.size = size; req.strb = '1; req.valid = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!arvalid_o && t < 20);
        chk("req_to_ar_latency", t, 1);
        ar_addr_cap = araddr_o; ar_len_cap = arlen_o;
        repeat (ar_stall) begin @(posedge clk); #1; end
        arready_i = 1'b1;
        @(posedge clk); #1;
        arready_i = 1'b0; req.valid = 1'b0;
    endtask

    // nbeats is what the slave sends; err_beat/last_beat are 1-based, 0 = never
    task automatic do_burst(input logic [31:0] addr, input logic [7:0] alen, input logic [2:0] size,
                            input int nbeats, input int err_beat, input int last_beat,
                            input int ar_stall, input bit gaps);
        int t, r0, f0, p0;
        r0 = n_ready; f0 = n_finish; p0 = pops.size();
        start_req(addr, alen, size, ar_stall);
        for (int k = 1; k <= nbeats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                rvalid_i = 1'b1; rid_i = 4'(ID + 4'd1); rdata_i = rand_data(); rlast_i = 1'b1;
                @(posedge clk); #1;
                rvalid_i = 1'b0; rid_i = ID; rlast_i = 1'b0;
            end
            send_beat((k == err_beat) ? 2'b10 : 2'b00, k == last_beat);
        end
        t = 0;
        while (rd_valid_o && t < 100) begin @(posedge clk); #1; t++; end
        chk("drain", rd_valid_o, 1'b0);
        @(posedge clk); #1;
        chk("ready_pulses", n_ready - r0, 1);
        chk("finish_pulses", n_finish - f0, 1);
        chk("beats_out", pops.size() - p0, nbeats);
        for (int i = p0; i < pops.size(); i++)
            chk("last_flag", pops[i].last, i == pops.size() - 1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; err_clr_i = 1'b1;
        @(posedge clk); #1; err_clr_i = 1'b0;
    endtask

    initial begin
        int alen, nb, eb, lb;
        rstn = 1'b0; req = '0; arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        rresp_i = 2'b00; rlast_i = 1'b0; rid_i = ID; err_clr_i = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst_arvalid", arvalid_o, 1'b0);
        chk("rst_rd_valid", rd_valid_o, 1'b0);
        chk("rst_arburst", arburst_o, 2'b01);
        chk("rst_arid", arid_o, 4'd3);

        // single beat
        do_burst(32'h1000, 8'd0, 3'd6, 1, 0, 1, 0, 1'b0);
        chk("single_araddr", ar_addr_cap, 32'h1000);
        chk("single_arlen", ar_len_cap, 8'd0);
        chk("single_last", pops[pops.size()-1].last, 1'b1);
        chk("single_err", rd_err_o.valid, 1'b0);

        // 16 beats with toggling back-pressure
        bp_mode = 1;
        do_burst(32'h0000_4000, 8'd15, 3'd6, 16, 0, 16, 0, 1'b0);
        bp_mode = 0;

        // AR stall
        do_burst(32'h0000_5040, 8'd2, 3'd5, 3, 0, 3, 5, 1'b0);
        chk("stall_araddr", ar_addr_cap, 32'h0000_5040);

        // SLVERR on beat 2 of 4
        do_burst(32'h2000, 8'd3, 3'd6, 4, 2, 4, 0, 1'b0);
        chk("slverr_valid", rd_err_o.valid, 1'b1);
        chk("slverr_addr", rd_err_o.addr, 32'h2000);
        pulse_clr();
        @(negedge clk);
        chk("clr_valid", rd_err_o.valid, 1'b0);

        // early last, then missing last
        do_burst(32'h2400, 8'd3, 3'd6, 2, 0, 2, 0, 1'b0);
        chk("early_err", rd_err_o.valid, 1'b1);
        pulse_clr();
        do_burst(32'h2800, 8'd1, 3'd6, 2, 0, 0, 0, 1'b0);
        chk("missing_err", rd_err_o.valid, 1'b1);
        chk("missing_addr", rd_err_o.addr, 32'h2800);
        pulse_clr();

        // clear held through an erroring beat wins
        err_clr_i = 1'b1;
        do_burst(32'h2c00, 8'd1, 3'd6, 2, 1, 2, 0, 1'b0);
        err_clr_i = 1'b0;
        chk("clr_priority", rd_err_o.valid, 1'b0);

        // randomized bursts
        for (int n = 0; n < 25; n++) begin
            bp_mode = $urandom_range(0, 2);
            alen = $urandom_range(0, 7);
            nb = alen + 1; lb = nb;
            case ($urandom_range(0, 5))
                0: if (alen > 0) begin lb = $urandom_range(1, alen); nb = lb; end
                1: lb = 0;
                default: ;
            endcase
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb) : 0;
            do_burst($urandom() & 32'hffff_ffc0, 8'(alen), 3'($urandom_range(0, 6)),
                     nb, eb, lb, $urandom_range(0, 3), 1'b1);
            if ($urandom_range(0, 2) == 0) pulse_clr();
        end
        bp_mode = 0;
        pulse_clr();

        // reset mid-burst with a full buffer
        bp_mode = 3;
        repeat (2) @(posedge clk);
        start_req(32'h3000, 8'd7, 3'd6, 0);
        send_beat(2'b00, 1'b0);
        send_beat(2'b00, 1'b0);
        @(negedge clk);
        chk("full_rready", rready_o, 1'b0);
        chk("full_rd_valid", rd_valid_o, 1'b1);
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst2_rd_valid", rd_valid_o, 1'b0);
        chk("rst2_rready", rready_o, 1'b0);
        chk("rst2_rd_data", rd_data_o, '0);
        chk("rst2_araddr", araddr_o, 32'h0);
        chk("rst2_ready", resp.ready, 1'b0);
        bp_mode = 0;
        do_burst(32'h3100, 8'd1, 3'd6, 2, 0, 2, 0, 1'b0);
        chk("after_rst_err", rd_err_o.valid, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
